// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Types and constants shared by the next-PC logic.
//   pc_src_t    : successor-PC selector coming from EX resolution.
//   pcu_state_t : fetch-PC controller state.
//   IALIGN_MASK : low PC bits that must be zero for a legal fetch target.
//   INSTR_BYTES : sequential fetch step.
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JAL  = 2'b01,
    PC_JALR = 2'b10,
    PC_BR   = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } pcu_state_t;

  // Only bit 1 is tested: jalr targets have bit 0 cleared, and pc-relative
  // targets are architecturally even, so bit 1 alone decides 4-byte alignment.
  localparam logic [1:0] IALIGN_MASK = 2'b10;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_next_unit_if.sv
// ---------------------------------------------------------------------------
// pc_next_unit_if
//   Bundles the control-transfer inputs (EX resolution, hazard stall, fetch
//   ready) and the fetch-request outputs of the next-PC unit.
//   master : the core side driving redirects/stalls and consuming pc.
//   slave  : the next-PC unit itself.
// ---------------------------------------------------------------------------
interface pc_next_unit_if
  import core_pkg::*;
#(
  parameter int unsigned W = 32
);

  pc_src_t        pc_src;
  logic           redirect_valid;
  logic [W-1:0]   pc_add_imm;
  logic [W-1:0]   alu_out;
  logic           stall;
  logic           if_ready;
  logic [W-1:0]   pc;
  logic           pc_valid;
  logic           flush;
  logic           misalign_trap;
  logic [W-1:0]   trap_pc;

  modport master (
    output pc_src, redirect_valid, pc_add_imm, alu_out, stall, if_ready,
    input  pc, pc_valid, flush, misalign_trap, trap_pc
  );

  modport slave (
    input  pc_src, redirect_valid, pc_add_imm, alu_out, stall, if_ready,
    output pc, pc_valid, flush, misalign_trap, trap_pc
  );

endinterface

// File: rtl/pc_target_sel.sv
// ---------------------------------------------------------------------------
// pc_target_sel
//   Combinational redirect-target selection.
//   pc_src_i      : selector (jal/branch use pc_add_imm_i, jalr uses alu_out_i)
//   pc_add_imm_i  : PC+imm from EX
//   alu_out_i     : rs1+imm from EX (jalr, LSB not yet cleared)
//   raw_tgt_o     : architectural target (reported as trap_pc on a trap)
//   next_tgt_o    : target actually loaded: raw target, or TRAP_VEC if misaligned
//   misalign_o    : raw target is not 4-byte aligned
// ---------------------------------------------------------------------------
module pc_target_sel
  import core_pkg::*;
#(
  parameter int unsigned    W        = 32,
  parameter logic [W-1:0]   TRAP_VEC = W'(32'h0000_0100)
) (
  input  pc_src_t         pc_src_i,
  input  logic [W-1:0]    pc_add_imm_i,
  input  logic [W-1:0]    alu_out_i,
  output logic [W-1:0]    raw_tgt_o,
  output logic [W-1:0]    next_tgt_o,
  output logic            misalign_o
);

  always_comb begin
    raw_tgt_o = pc_add_imm_i;
    if (pc_src_i == PC_JALR) begin
      // jalr discards the LSB of rs1+imm
      raw_tgt_o = {alu_out_i[W-1:1], 1'b0};
    end
    misalign_o = |(raw_tgt_o[1:0] & IALIGN_MASK);
    next_tgt_o = misalign_o ? TRAP_VEC : raw_tgt_o;
  end

endmodule

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//   Owns the fetch PC. Advances sequentially when fetch accepts and IF is not
//   stalled, takes EX redirects (with flush pulse), parks a redirect target in
//   a pending buffer while fetch cannot accept, and diverts misaligned targets
//   to TRAP_VEC while latching the offending address.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pc_next_unit_if (redirect/stall/ready in,
//           pc/pc_valid/flush/misalign_trap/trap_pc out)
// ---------------------------------------------------------------------------
module pc_next_unit
  import core_pkg::*;
#(
  parameter int unsigned    W         = 32,
  parameter logic [W-1:0]   RESET_VEC = W'(32'h0000_0000),
  parameter logic [W-1:0]   TRAP_VEC  = W'(32'h0000_0100)
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_next_unit_if.slave     bus
);

  pcu_state_t   state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pend_tgt_q, pend_tgt_d;
  logic         trap_q, trap_d;
  logic [W-1:0] trap_pc_q, trap_pc_d;

  logic [W-1:0] raw_tgt;
  logic [W-1:0] next_tgt;
  logic         misalign;
  logic         advance;
  logic         redirect;

  pc_target_sel #(
    .W        (W),
    .TRAP_VEC (TRAP_VEC)
  ) u_target_sel (
    .pc_src_i     (bus.pc_src),
    .pc_add_imm_i (bus.pc_add_imm),
    .alu_out_i    (bus.alu_out),
    .raw_tgt_o    (raw_tgt),
    .next_tgt_o   (next_tgt),
    .misalign_o   (misalign)
  );

  assign advance = bus.if_ready & ~bus.stall;

  // Redirects are only honoured once out of BOOT; pc_src=SEQ is not a transfer.
  assign redirect = bus.redirect_valid & (bus.pc_src != PC_SEQ) & (state_q != BOOT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    trap_d     = 1'b0;
    trap_pc_d  = trap_pc_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, PEND: begin
        if (redirect) begin
          if (misalign) begin
            trap_d    = 1'b1;
            trap_pc_d = raw_tgt;
          end
          // A new redirect always supersedes an older pending one.
          if (advance) begin
            pc_d    = next_tgt;
            state_d = RUN;
          end else begin
            pend_tgt_d = next_tgt;
            state_d    = PEND;
          end
        end else if (advance) begin
          if (state_q == PEND) begin
            pc_d    = pend_tgt_q;
            state_d = RUN;
          end else begin
            pc_d = pc_q + W'(INSTR_BYTES);
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pend_tgt_q <= '0;
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      trap_q     <= trap_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = (state_q == RUN);
  assign bus.flush         = redirect;
  assign bus.misalign_trap = trap_q;
  assign bus.trap_pc       = trap_pc_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_next_unit
//   Directed scenarios followed by randomized redirect/stall/ready/reset
//   traffic, all checked against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_pc_next_unit;
  import core_pkg::*;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic clk;
  logic rst_n;

  pc_next_unit_if #(.W(32)) bus ();

  pc_next_unit #(
    .W         (32),
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_trap_pc;
  bit          m_booted;
  bit          m_pending;
  bit          m_trap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_VEC;
    m_pend    = '0;
    m_trap_pc = '0;
    m_booted  = 0;
    m_pending = 0;
    m_trap    = 0;
  endtask

  function automatic bit model_flush();
    return m_booted && bus.redirect_valid && (bus.pc_src != PC_SEQ);
  endfunction

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    logic [31:0] tgt;
    bit adv;
    m_trap = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_booted) begin
      m_booted = 1;
    end else begin
      adv = bus.if_ready && !bus.stall;
      if (bus.redirect_valid && bus.pc_src != PC_SEQ) begin
        tgt = (bus.pc_src == PC_JALR) ? (bus.alu_out & 32'hFFFF_FFFE) : bus.pc_add_imm;
        if (tgt[1]) begin
          m_trap    = 1;
          m_trap_pc = tgt;
          tgt       = TRAP_VEC;
        end
        if (adv) begin
          m_pc      = tgt;
          m_pending = 0;
        end else begin
          m_pend    = tgt;
          m_pending = 1;
        end
      end else if (adv) begin
        if (m_pending) begin
          m_pc      = m_pend;
          m_pending = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic set_in(input bit rv, input pc_src_t src, input logic [31:0] imm,
                        input logic [31:0] alu, input bit stl, input bit rdy);
    bus.redirect_valid = rv;
    bus.pc_src         = src;
    bus.pc_add_imm     = imm;
    bus.alu_out        = alu;
    bus.stall          = stl;
    bus.if_ready       = rdy;
  endtask

  task automatic chk_regs();
    chk("pc", bus.pc, m_pc);
    chk("pc_valid", 32'(bus.pc_valid), 32'(m_booted && !m_pending));
    chk("trap", 32'(bus.misalign_trap), 32'(m_trap));
    chk("trap_pc", bus.trap_pc, m_trap_pc);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    #1;
    chk("flush", 32'(bus.flush), 32'(model_flush()));
    @(posedge clk);
    model_edge();
    #1;
    chk_regs();
    @(negedge clk);
  endtask

  task automatic idle();
    set_in(0, PC_SEQ, 32'h0, 32'h0, 0, 1);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, PC_SEQ, 32'h0, 32'h0, 0, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_pc", bus.pc, RESET_VEC);
    chk("rst_valid", 32'(bus.pc_valid), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_trap", 32'(bus.misalign_trap), 32'd0);
    chk("rst_trap_pc", bus.trap_pc, 32'd0);

    // 1: boot, then sequential fetch
    rst_n = 1'b1;
    idle();
    chk("t1_boot_pc", bus.pc, 32'h0);
    chk("t1_boot_valid", 32'(bus.pc_valid), 32'd1);
    idle(); chk("t1_pc4", bus.pc, 32'h4);
    idle(); chk("t1_pc8", bus.pc, 32'h8);
    idle(); chk("t1_pc12", bus.pc, 32'hC);
    idle(); chk("t1_pc16", bus.pc, 32'h10);

    // 2: jal redirect unstalled
    set_in(1, PC_JAL, 32'h200, 32'h0, 0, 1);
    #1 chk("t2_flush", 32'(bus.flush), 32'd1);
    cyc();
    chk("t2_pc", bus.pc, 32'h200);
    idle(); chk("t2_pc_seq", bus.pc, 32'h204);

    // 3: jalr LSB clear, then misaligned jalr
    set_in(1, PC_JALR, 32'h0, 32'h301, 0, 1);
    cyc();
    chk("t3_pc300", bus.pc, 32'h300);
    chk("t3_notrap", 32'(bus.misalign_trap), 32'd0);
    set_in(1, PC_JALR, 32'h0, 32'h302, 0, 1);
    cyc();
    chk("t3_trapvec", bus.pc, TRAP_VEC);
    chk("t3_trap", 32'(bus.misalign_trap), 32'd1);
    chk("t3_trap_pc", bus.trap_pc, 32'h302);
    idle();
    chk("t3_trap_pulse", 32'(bus.misalign_trap), 32'd0);
    chk("t3_trap_hold", bus.trap_pc, 32'h302);

    // 4: branch under 3-cycle stall
    set_in(1, PC_BR, 32'h80, 32'h0, 1, 1);
    cyc();
    chk("t4_hold", bus.pc, 32'h104);
    chk("t4_novalid", 32'(bus.pc_valid), 32'd0);
    set_in(0, PC_SEQ, 32'h0, 32'h0, 1, 1);
    cyc();
    cyc();
    chk("t4_hold3", bus.pc, 32'h104);
    idle();
    chk("t4_pc80", bus.pc, 32'h80);
    chk("t4_valid", 32'(bus.pc_valid), 32'd1);

    // 5: newer redirect overwrites pending one
    set_in(1, PC_BR, 32'h80, 32'h0, 1, 1);
    cyc();
    set_in(1, PC_JAL, 32'h400, 32'h0, 1, 1);
    #1 chk("t5_flush", 32'(bus.flush), 32'd1);
    cyc();
    idle();
    chk("t5_pc400", bus.pc, 32'h400);
    idle();
    chk("t5_pc404", bus.pc, 32'h404);

    // 6: wrap-around, then async reset while pending
    set_in(1, PC_JAL, 32'hFFFF_FFFC, 32'h0, 0, 1);
    cyc();
    idle();
    chk("t6_wrap", bus.pc, 32'h0);
    idle();
    set_in(1, PC_BR, 32'h500, 32'h0, 1, 1);
    cyc();
    chk("t6_pend_pc", bus.pc, 32'h4);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_pc", bus.pc, RESET_VEC);
    chk("t6_rst_valid", 32'(bus.pc_valid), 32'd0);
    chk("t6_rst_trap_pc", bus.trap_pc, 32'd0);
    cyc();
    rst_n = 1'b1;
    idle();
    idle();
    chk("t6_after_rst", bus.pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      logic [31:0] alu;
      imm = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 5) == 0) imm[1] = 1'b1;
      alu = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 2) != 0) alu[1] = 1'b0;
      set_in($urandom_range(0, 3) == 0, pc_src_t'($urandom_range(0, 3)), imm, alu,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 chk("rnd_async_pc", bus.pc, RESET_VEC);
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
